// File: rtl/min_max_job_scheduler.sv
// Round-robin front end sharing one 16x8 min/max finder between two requesters.
// Optional WAIT timeout is enabled by defining MMS_TIMEOUT_EN.
module min_max_job_scheduler #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [1:0]                   Req,
    input  logic [(DATA_W<<ADDR_W)-1:0]  Req0_data,
    input  logic [(DATA_W<<ADDR_W)-1:0]  Req1_data,
    input  logic [1:0]                   Rsp_ready,
    output logic [1:0]                   Rsp_valid,
    output logic [DATA_W-1:0]            Rsp_max,
    output logic [DATA_W-1:0]            Rsp_min,
    output logic                         Rsp_err,
    output logic                         Fw_we,
    output logic [ADDR_W-1:0]            Fw_addr,
    output logic [DATA_W-1:0]            Fw_data,
    output logic                         Fs_start,
    input  logic                         Fs_done,
    input  logic [DATA_W-1:0]            Fs_max,
    input  logic [DATA_W-1:0]            Fs_min,
    output logic                         Busy,
    output logic                         Gnt_id,
    output logic [7:0]                   Jobs_done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STRT, S_WAIT, S_RESP} state_t;

    state_t                 state_q;
    logic                   gnt_q, last_gnt_q, strt_q, seen0_q;
    logic [1:0]             valid_q;
    logic [DATA_W-1:0]      max_q, min_q, data_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   we_q, start_q;
    logic [7:0]             jobs_q;

    logic                   gnt_d, sel_id;
    logic [ADDR_W-1:0]      addr_d;
    logic [DATA_W-1:0]      byte_d;
    logic [(DATA_W<<ADDR_W)-1:0] sel_arr;

    // Both requesting: the one not served last wins.
    assign gnt_d   = (Req == 2'b11) ? ~last_gnt_q : Req[1];
    assign sel_id  = (state_q == S_IDLE) ? gnt_d : gnt_q;
    assign addr_d  = (state_q == S_IDLE) ? '0 : addr_q + 1'b1;
    assign sel_arr = sel_id ? Req1_data : Req0_data;
    assign byte_d  = sel_arr[DATA_W*int'(addr_d) +: DATA_W];

`ifdef MMS_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       err_q;
    assign Rsp_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign Rsp_err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            strt_q     <= 1'b0;
            seen0_q    <= 1'b0;
            valid_q    <= 2'b00;
            max_q      <= '0;
            min_q      <= '1;
            data_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            start_q    <= 1'b0;
            jobs_q     <= 8'd0;
`ifdef MMS_TIMEOUT_EN
            to_cnt_q   <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (Req != 2'b00) begin
                    gnt_q   <= gnt_d;
                    we_q    <= 1'b1;
                    addr_q  <= addr_d;
                    data_q  <= byte_d;
                    state_q <= S_LOAD;
                end
                S_LOAD: if (addr_q == '1) begin
                    we_q    <= 1'b0;
                    start_q <= 1'b1;
                    strt_q  <= 1'b0;
                    state_q <= S_STRT;
                end else begin
                    addr_q  <= addr_d;
                    data_q  <= byte_d;
                end
                // Start is held two cycles so a finder parked in DONE or INI both see it.
                S_STRT: if (strt_q) begin
                    start_q <= 1'b0;
                    seen0_q <= 1'b0;
`ifdef MMS_TIMEOUT_EN
                    to_cnt_q <= 8'd0;
`endif
                    state_q <= S_WAIT;
                end else begin
                    strt_q  <= 1'b1;
                end
                S_WAIT: if (Fs_done && seen0_q) begin
                    max_q   <= Fs_max;
                    min_q   <= Fs_min;
`ifdef MMS_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    valid_q <= gnt_q ? 2'b10 : 2'b01;
                    state_q <= S_RESP;
                end else begin
                    if (!Fs_done) seen0_q <= 1'b1;
`ifdef MMS_TIMEOUT_EN
                    if (to_cnt_q == 8'(TIMEOUT - 1)) begin
                        max_q   <= '0;
                        min_q   <= '1;
                        err_q   <= 1'b1;
                        valid_q <= gnt_q ? 2'b10 : 2'b01;
                        state_q <= S_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
`endif
                end
                S_RESP: if (Rsp_ready[gnt_q]) begin
                    valid_q    <= 2'b00;
                    last_gnt_q <= gnt_q;
                    jobs_q     <= jobs_q + 8'd1;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Rsp_valid = valid_q;
    assign Rsp_max   = max_q;
    assign Rsp_min   = min_q;
    assign Fw_we     = we_q;
    assign Fw_addr   = addr_q;
    assign Fw_data   = data_q;
    assign Fs_start  = start_q;
    assign Busy      = (state_q != S_IDLE);
    assign Gnt_id    = gnt_q;
    assign Jobs_done = jobs_q;
endmodule

// File: tb/tb_min_max_job_scheduler.sv
// Scoreboard bench for min_max_job_scheduler with a behavioural finder and random jobs.
module tb_min_max_job_scheduler;
    logic         Clk = 1'b0;
    logic         Reset_n;
    logic [1:0]   Req;
    logic [127:0] Req0_data, Req1_data;
    logic [1:0]   Rsp_ready;
    logic [1:0]   Rsp_valid;
    logic [7:0]   Rsp_max, Rsp_min;
    logic         Rsp_err, Fw_we, Fs_start, Fs_done, Busy, Gnt_id;
    logic [3:0]   Fw_addr;
    logic [7:0]   Fw_data, Fs_max, Fs_min, Jobs_done;

    min_max_job_scheduler dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Req0_data(Req0_data), .Req1_data(Req1_data),
        .Rsp_ready(Rsp_ready), .Rsp_valid(Rsp_valid), .Rsp_max(Rsp_max), .Rsp_min(Rsp_min),
        .Rsp_err(Rsp_err), .Fw_we(Fw_we), .Fw_addr(Fw_addr), .Fw_data(Fw_data),
        .Fs_start(Fs_start), .Fs_done(Fs_done), .Fs_max(Fs_max), .Fs_min(Fs_min),
        .Busy(Busy), .Gnt_id(Gnt_id), .Jobs_done(Jobs_done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic         id;
        logic [127:0] arr;
        logic [7:0]   mx;
        logic [7:0]   mn;
    } job_t;

    job_t exp_q[$];
    int   tests = 0, fails = 0;
    int   hs_cnt[2], seen[2];
    int   wr_k = 0;
    int   stall_left = 0;
    int   jobs_m = 0;
    logic last_m = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_ext(input logic [127:0] a, input bit want_max);
        logic [7:0] r, b;
        r = want_max ? 8'h00 : 8'hFF;
        for (int k = 0; k < 16; k++) begin
            b = a[k*8 +: 8];
            if (want_max ? (b > r) : (b < r)) r = b;
        end
        return r;
    endfunction

    // Behavioural finder: memory, Start, variable run time, optionally slow to clear Done.
    logic [7:0] fmem [16];
    logic       f_done = 1'b0, f_armed = 1'b0, f_run = 1'b0, f_slug = 1'b0;
    logic [7:0] f_max = 8'h00, f_min = 8'hFF;
    int         f_cnt = 0;
    assign Fs_done = f_done;
    assign Fs_max  = f_max;
    assign Fs_min  = f_min;

    function automatic logic [7:0] scan(input bit want_max);
        logic [7:0] r;
        r = want_max ? 8'h00 : 8'hFF;
        for (int k = 0; k < 16; k++)
            if (want_max ? (fmem[k] > r) : (fmem[k] < r)) r = fmem[k];
        return r;
    endfunction

    always @(posedge Clk) begin
        if (!Reset_n) begin
            f_done <= 1'b0; f_armed <= 1'b0; f_run <= 1'b0;
        end else begin
            if (Fw_we) fmem[Fw_addr] <= Fw_data;
            if (Fs_start) begin
                if (!f_slug) f_done <= 1'b0;
                f_armed <= 1'b1;
            end else if (f_armed) begin
                f_armed <= 1'b0; f_done <= 1'b0; f_run <= 1'b1;
                f_cnt   <= $urandom_range(0, 6);
                f_slug  <= 1'($urandom_range(0, 1));
            end else if (f_run) begin
                if (f_cnt == 0) begin
                    f_run <= 1'b0; f_done <= 1'b1;
                    f_max <= scan(1'b1); f_min <= scan(1'b0);
                end else begin
                    f_cnt <= f_cnt - 1;
                end
            end
        end
    end

    // Monitor: checks finder writes and every response cycle against the queue head.
    logic       stall_prev = 1'b0;
    logic [7:0] p_max, p_min;
    logic [1:0] p_valid;
    initial begin
        job_t j;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                wr_k = 0; stall_prev = 1'b0;
            end else begin
                if (Fw_we) begin
                    if (exp_q.size() == 0) chk("fw_unexpected", 32'(Fw_we), 32'd0);
                    else begin
                        j = exp_q[0];
                        chk("fw_addr", 32'(Fw_addr), 32'(wr_k));
                        chk("fw_data", 32'(Fw_data), 32'(j.arr[wr_k*8 +: 8]));
                        wr_k = (wr_k + 1) % 16;
                    end
                end
                if (Rsp_valid != 2'b00) begin
                    if (exp_q.size() == 0) chk("rsp_unexpected", 32'(Rsp_valid), 32'd0);
                    else begin
                        j = exp_q[0];
                        chk("rsp_valid", 32'(Rsp_valid), j.id ? 32'd2 : 32'd1);
                        chk("gnt_id", 32'(Gnt_id), 32'(j.id));
                        chk("rsp_max", 32'(Rsp_max), 32'(j.mx));
                        chk("rsp_min", 32'(Rsp_min), 32'(j.mn));
                        chk("rsp_err", 32'(Rsp_err), 32'd0);
                        chk("busy_resp", 32'(Busy), 32'd1);
                        if (stall_prev) begin
                            chk("hold_valid", 32'(Rsp_valid), 32'(p_valid));
                            chk("hold_max", 32'(Rsp_max), 32'(p_max));
                            chk("hold_min", 32'(Rsp_min), 32'(p_min));
                            chk("stall_fw_we", 32'(Fw_we), 32'd0);
                            chk("stall_start", 32'(Fs_start), 32'd0);
                        end
                        if (Rsp_ready[j.id]) begin
                            void'(exp_q.pop_front());
                            hs_cnt[j.id]++;
                            stall_prev = 1'b0;
                        end else begin
                            stall_prev = 1'b1;
                            p_valid = Rsp_valid; p_max = Rsp_max; p_min = Rsp_min;
                        end
                    end
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
    end

    task automatic chk_reset();
        chk("rst_valid", 32'(Rsp_valid), 32'd0);
        chk("rst_max", 32'(Rsp_max), 32'd0);
        chk("rst_min", 32'(Rsp_min), 32'hFF);
        chk("rst_err", 32'(Rsp_err), 32'd0);
        chk("rst_fw_we", 32'(Fw_we), 32'd0);
        chk("rst_fw_addr", 32'(Fw_addr), 32'd0);
        chk("rst_fw_data", 32'(Fw_data), 32'd0);
        chk("rst_start", 32'(Fs_start), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_gnt", 32'(Gnt_id), 32'd0);
        chk("rst_jobs", 32'(Jobs_done), 32'd0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; Req = 2'b00; Rsp_ready = 2'b00;
        #1;
        chk_reset();
        exp_q.delete();
        last_m = 1'b1; jobs_m = 0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    task automatic push_job(input logic id, input logic [127:0] a);
        job_t j;
        j.id = id; j.arr = a;
        j.mx = ref_ext(a, 1'b1); j.mn = ref_ext(a, 1'b0);
        exp_q.push_back(j);
    endtask

    task automatic run_round(input logic [1:0] p, input logic [127:0] d0, input logic [127:0] d1,
                             input int stall);
        int  n;
        bit  done;
        Req0_data = d0; Req1_data = d1;
        if (p == 2'b11) begin
            push_job(~last_m, ~last_m ? d1 : d0);
            push_job(last_m, last_m ? d1 : d0);
            n = 2;
        end else begin
            push_job(p[1], p[1] ? d1 : d0);
            last_m = p[1];
            n = 1;
        end
        stall_left = stall;
        Req = p;
        done = 1'b0;
        for (int c = 0; c < 800 && !done; c++) begin
            @(posedge Clk); #1;
            for (int i = 0; i < 2; i++)
                if (hs_cnt[i] != seen[i]) begin
                    seen[i] = hs_cnt[i];
                    Req[i] = 1'b0;
                end
            if (Req == 2'b00 && exp_q.size() == 0) done = 1'b1;
            else if (Rsp_valid != 2'b00 && stall_left > 0) begin
                stall_left--;
                Rsp_ready = 2'b00;
            end else begin
                Rsp_ready = 2'($urandom_range(0, 3));
            end
        end
        Rsp_ready = 2'b00;
        chk("round_complete", 32'(done), 32'd1);
        if (!done) begin
            exp_q.delete(); Req = 2'b00;
        end
        jobs_m = (jobs_m + n) % 256;
        chk("jobs_done", 32'(Jobs_done), 32'(jobs_m));
        chk("busy_idle", 32'(Busy), 32'd0);
    endtask

    localparam logic [127:0] T1A = 128'hF584_0202_9902_85F4_F423_8390_F464_9A3B;
    localparam logic [127:0] T2B = 128'h01B9_3953_0909_7391_A9A9_2931_3131_5693;

    initial begin
        logic [127:0] ra, rb;
        bit           hit;
        hs_cnt[0] = 0; hs_cnt[1] = 0; seen[0] = 0; seen[1] = 0;
        Req = 2'b00; Rsp_ready = 2'b00; Req0_data = '0; Req1_data = '0;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        do_reset();

        run_round(2'b01, T1A, T2B, 0);
        do_reset();
        run_round(2'b11, T1A, T2B, 0);
        run_round(2'b01, T2B, T1A, 10);
        run_round(2'b11, T1A, T2B, 0);
        run_round(2'b11, T2B, T1A, 3);

        // Reset in the middle of loading, then confirm a clean restart.
        ra = {$urandom, $urandom, $urandom, $urandom};
        Req0_data = ra;
        push_job(1'b0, ra);
        Req = 2'b01;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge Clk); #1;
            if (Fw_we && Fw_addr == 4'd7) hit = 1'b1;
        end
        chk("t5_reached_addr7", 32'(hit), 32'd1);
        do_reset();
        run_round(2'b01, ra, T2B, 0);

        run_round(2'b11, {16{8'hFF}}, {16{8'h00}}, 0);
        run_round(2'b10, {16{8'h5A}}, {16{8'h5A}}, 0);
        for (int r = 0; r < 30; r++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            run_round(2'($urandom_range(1, 3)), ra, rb, (r % 7 == 0) ? 5 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
